// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: scans a sprite table at line start,
// hands hits to free draw engines and merges engine pixels by priority.
module sprite_scheduler #(
    parameter int NUM_SPR = 8,
    parameter int NUM_ENG = 4,
    parameter int XW      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [XW-1:0]              pixel_y,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_SPR)-1:0] wr_idx,
    input  logic                       wr_valid,
    input  logic [2:0]                 wr_type,
    input  logic [XW-1:0]              wr_x,
    input  logic [XW-1:0]              wr_y,
    input  logic [NUM_ENG-1:0]         eng_busy,
    input  logic [NUM_ENG-1:0]         eng_draw,
    output logic [NUM_ENG-1:0]         eng_start,
    output logic [3*NUM_ENG-1:0]       eng_sprite,
    output logic [XW*NUM_ENG-1:0]      eng_x,
    output logic                       pix_on,
    output logic [2:0]                 pix_type,
    output logic                       ovf,
    output logic                       overrun,
    input  logic                       clr
);

    localparam int IW = $clog2(NUM_SPR);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_ENG-1:0]   alloc_q, alloc_d;

    logic [NUM_SPR-1:0]   tvalid_q;
    logic [2:0]           ttype_q [NUM_SPR];
    logic [XW-1:0]        tx_q    [NUM_SPR];
    logic [XW-1:0]        ty_q    [NUM_SPR];

    logic [NUM_ENG-1:0]   start_q;
    logic [2:0]           spr_q   [NUM_ENG];
    logic [XW-1:0]        x_q     [NUM_ENG];
    logic [IW-1:0]        own_q   [NUM_ENG];

    logic                 pix_on_q;
    logic [2:0]           pix_type_q;
    logic                 ovf_q;
    logic                 overrun_q;

    logic                 hit;
    logic                 found;
    logic                 alloc;
    logic                 drop;
    logic [NUM_ENG-1:0]   grant;
    logic                 win_any;
    logic [IW-1:0]        win_own;
    logic [2:0]           win_type;

    // Sprite table: writes land at the clock edge, the scan sees old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_q <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                ttype_q[i] <= '0;
                tx_q[i]    <= '0;
                ty_q[i]    <= '0;
            end
        end else if (wr_en) begin
            tvalid_q[wr_idx] <= wr_valid;
            ttype_q[wr_idx]  <= wr_type;
            tx_q[wr_idx]     <= wr_x;
            ty_q[wr_idx]     <= wr_y;
        end
    end

    // Hit test on the visited entry and lowest-index free engine pick
    always_comb begin
        hit   = 1'b0;
        found = 1'b0;
        grant = '0;
        if (state_q == SCAN) begin
            hit = tvalid_q[idx_q] && (ty_q[idx_q] == pixel_y);
        end
        for (int e = 0; e < NUM_ENG; e++) begin
            if (!found && !eng_busy[e] && !alloc_q[e]) begin
                grant[e] = 1'b1;
                found    = 1'b1;
            end
        end
        alloc = hit && found;
        drop  = hit && !found;
    end

    // Scan FSM next state: one table entry per cycle, mask clears at end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        alloc_d = alloc_q;
        unique case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (alloc) alloc_d = alloc_q | grant;
                if (idx_q == IW'(NUM_SPR - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    alloc_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            alloc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            alloc_q <= alloc_d;
        end
    end

    // Engine start pulse and held engine inputs / owner records
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            for (int e = 0; e < NUM_ENG; e++) begin
                spr_q[e] <= '0;
                x_q[e]   <= '0;
                own_q[e] <= '0;
            end
        end else begin
            start_q <= alloc ? grant : '0;
            for (int e = 0; e < NUM_ENG; e++) begin
                if (alloc && grant[e]) begin
                    spr_q[e] <= ttype_q[idx_q];
                    x_q[e]   <= tx_q[idx_q];
                    own_q[e] <= idx_q;
                end
            end
        end
    end

    // Sticky error flags; clear wins over a same-cycle set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clr) begin
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            if (line_start && state_q == SCAN) overrun_q <= 1'b1;
        end
    end

    // Merge winner: lowest owner index, ties to the lower engine
    always_comb begin
        win_any  = 1'b0;
        win_own  = '0;
        win_type = '0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (eng_draw[e] && (!win_any || own_q[e] < win_own)) begin
                win_any  = 1'b1;
                win_own  = own_q[e];
                win_type = spr_q[e];
            end
        end
    end

    // Registered merged pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_on_q   <= 1'b0;
            pix_type_q <= '0;
        end else begin
            pix_on_q   <= |eng_draw;
            pix_type_q <= win_type;
        end
    end

    for (genvar e = 0; e < NUM_ENG; e++) begin : g_pack
        assign eng_sprite[3*e +: 3] = spr_q[e];
        assign eng_x[XW*e +: XW]    = x_q[e];
    end

    assign eng_start = start_q;
    assign pix_on    = pix_on_q;
    assign pix_type  = pix_type_q;
    assign ovf       = ovf_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: directed sequences, merge vector table
// and randomized lines checked against a table-level reference model.
module tb_sprite_scheduler;

    localparam int NS = 8;
    localparam int NE = 4;
    localparam int XW = 10;

    typedef logic [NE-1:0] busy_t [NS];

    typedef struct {
        logic [NE-1:0] draw;
        logic          on;
        logic [2:0]    typ;
    } mvec_t;

    logic              clk;
    logic              rst;
    logic              line_start;
    logic [XW-1:0]     pixel_y;
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic              wr_valid;
    logic [2:0]        wr_type;
    logic [XW-1:0]     wr_x;
    logic [XW-1:0]     wr_y;
    logic [NE-1:0]     eng_busy;
    logic [NE-1:0]     eng_draw;
    logic [NE-1:0]     eng_start;
    logic [3*NE-1:0]   eng_sprite;
    logic [XW*NE-1:0]  eng_x;
    logic              pix_on;
    logic [2:0]        pix_type;
    logic              ovf;
    logic              overrun;
    logic              clr;

    int n_cmp = 0;
    int n_err = 0;

    bit            m_valid [NS];
    logic [2:0]    m_type  [NS];
    logic [XW-1:0] m_xt    [NS];
    logic [XW-1:0] m_yt    [NS];
    logic [2:0]    m_spr   [NE];
    logic [XW-1:0] m_x     [NE];
    int            m_own   [NE];
    bit            m_ovf;

    sprite_scheduler #(.NUM_SPR(NS), .NUM_ENG(NE), .XW(XW)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .pixel_y(pixel_y),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_type(wr_type), .wr_x(wr_x), .wr_y(wr_y),
        .eng_busy(eng_busy), .eng_draw(eng_draw), .eng_start(eng_start),
        .eng_sprite(eng_sprite), .eng_x(eng_x), .pix_on(pix_on),
        .pix_type(pix_type), .ovf(ovf), .overrun(overrun), .clr(clr)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [XW*NE-1:0] pack_x();
        logic [XW*NE-1:0] r;
        r = '0;
        for (int e = 0; e < NE; e++) r[XW*e +: XW] = m_x[e];
        return r;
    endfunction

    function automatic logic [3*NE-1:0] pack_s();
        logic [3*NE-1:0] r;
        r = '0;
        for (int e = 0; e < NE; e++) r[3*e +: 3] = m_spr[e];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1;
        line_start = 0;
        pixel_y    = '0;
        wr_en      = 0;
        wr_idx     = '0;
        wr_valid   = 0;
        wr_type    = '0;
        wr_x       = '0;
        wr_y       = '0;
        eng_busy   = '0;
        eng_draw   = '0;
        clr        = 0;
        tick();
        rst = 0;
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 0;
            m_type[i]  = '0;
            m_xt[i]    = '0;
            m_yt[i]    = '0;
        end
        for (int e = 0; e < NE; e++) begin
            m_spr[e] = '0;
            m_x[e]   = '0;
            m_own[e] = 0;
        end
        m_ovf = 0;
    endtask

    task automatic wr(input int i, input bit v, input logic [2:0] t,
                      input logic [XW-1:0] x, input logic [XW-1:0] y);
        wr_en    = 1;
        wr_idx   = 3'(i);
        wr_valid = v;
        wr_type  = t;
        wr_x     = x;
        wr_y     = y;
        tick();
        wr_en      = 0;
        m_valid[i] = v;
        m_type[i]  = t;
        m_xt[i]    = x;
        m_yt[i]    = y;
    endtask

    // One full line: every table entry in order, hits go to the lowest
    // engine neither busy nor already handed a sprite this line.
    task automatic run_line(input logic [XW-1:0] y, input busy_t bs);
        logic [NE-1:0] mask;
        logic [NE-1:0] exp;
        int            sel;
        mask       = '0;
        pixel_y    = y;
        line_start = 1;
        tick();
        line_start = 0;
        for (int j = 0; j < NS; j++) begin
            eng_busy = bs[j];
            exp      = '0;
            if (m_valid[j] && m_yt[j] == y) begin
                sel = -1;
                for (int e = NE - 1; e >= 0; e--)
                    if (!bs[j][e] && !mask[e]) sel = e;
                if (sel < 0) begin
                    m_ovf = 1;
                end else begin
                    exp[sel]   = 1'b1;
                    mask[sel]  = 1'b1;
                    m_spr[sel] = m_type[j];
                    m_x[sel]   = m_xt[j];
                    m_own[sel] = j;
                end
            end
            tick();
            chk($sformatf("start y%0d entry%0d", y, j), 64'(eng_start), 64'(exp));
        end
        eng_busy = '0;
        chk("eng_x", 64'(eng_x), 64'(pack_x()));
        chk("eng_sprite", 64'(eng_sprite), 64'(pack_s()));
        chk("ovf", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic draw_chk(input logic [NE-1:0] d);
        int         best;
        logic [2:0] et;
        eng_draw = d;
        tick();
        best = -1;
        for (int e = 0; e < NE; e++)
            if (d[e] && (best < 0 || m_own[e] < m_own[best])) best = e;
        et = (best < 0) ? 3'd0 : m_spr[best];
        chk($sformatf("pix_on d%0h", d), 64'(pix_on), 64'(d != 0));
        chk($sformatf("pix_type d%0h", d), 64'(pix_type), 64'(et));
        eng_draw = '0;
    endtask

    task automatic pulse_clr();
        clr = 1;
        tick();
        clr   = 0;
        m_ovf = 0;
    endtask

    busy_t  bz;
    busy_t  bs;
    mvec_t  mv [8];
    logic [NE-1:0] acc;

    initial begin
        for (int j = 0; j < NS; j++) bz[j] = '0;
        rst = 1;
        #3;

        // reset state
        do_reset();
        chk("rst eng_start", 64'(eng_start), 64'd0);
        chk("rst eng_x", 64'(eng_x), 64'd0);
        chk("rst eng_sprite", 64'(eng_sprite), 64'd0);
        chk("rst pix_on", 64'(pix_on), 64'd0);
        chk("rst pix_type", 64'(pix_type), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        chk("rst overrun", 64'(overrun), 64'd0);

        // single sprite, neighbouring lines miss
        wr(2, 1, 3'd1, 10'd100, 10'd50);
        run_line(10'd49, bz);
        run_line(10'd51, bz);
        run_line(10'd50, bz);
        chk("x0 is 100", 64'(eng_x[9:0]), 64'd100);
        chk("spr0 is 1", 64'(eng_sprite[2:0]), 64'd1);

        // five hits, four engines
        do_reset();
        for (int i = 0; i < 5; i++) wr(i, 1, 3'(i + 1), 10'(10 * i), 10'd20);
        run_line(10'd20, bz);
        chk("ovf after 5 hits", 64'(ovf), 64'd1);
        pulse_clr();
        chk("ovf after clr", 64'(ovf), 64'd0);

        // busy engine 0 is skipped and keeps its x
        do_reset();
        wr(1, 1, 3'd2, 10'd55, 10'd24);
        wr(0, 1, 3'd3, 10'd77, 10'd25);
        run_line(10'd24, bz);
        bs = bz;
        bs[0] = 4'b0001;
        run_line(10'd25, bs);
        chk("busy skip x0", 64'(eng_x[9:0]), 64'd55);
        chk("busy skip x1", 64'(eng_x[19:10]), 64'd77);

        // merge priority: owners e0=0,e1=5,e2=3,e3=6
        do_reset();
        wr(0, 1, 3'd4, 10'd10, 10'd70);
        wr(3, 1, 3'd6, 10'd300, 10'd70);
        wr(5, 1, 3'd2, 10'd500, 10'd70);
        wr(6, 1, 3'd7, 10'd600, 10'd70);
        bs = bz;
        bs[3] = 4'b0010;
        run_line(10'd70, bs);
        mv[0] = '{4'b0110, 1'b1, 3'd6};
        mv[1] = '{4'b0000, 1'b0, 3'd0};
        mv[2] = '{4'b0010, 1'b1, 3'd2};
        mv[3] = '{4'b1010, 1'b1, 3'd2};
        mv[4] = '{4'b1000, 1'b1, 3'd7};
        mv[5] = '{4'b1111, 1'b1, 3'd4};
        mv[6] = '{4'b1100, 1'b1, 3'd6};
        mv[7] = '{4'b1001, 1'b1, 3'd4};
        for (int i = 0; i < 8; i++) begin
            eng_draw = mv[i].draw;
            tick();
            chk($sformatf("vec%0d pix_on", i), 64'(pix_on), 64'(mv[i].on));
            chk($sformatf("vec%0d pix_type", i), 64'(pix_type), 64'(mv[i].typ));
        end
        eng_draw = '0;

        // write during the scan of that entry, and a second line_start
        do_reset();
        wr(0, 1, 3'd3, 10'd111, 10'd31);
        wr(7, 1, 3'd6, 10'd700, 10'd30);
        pixel_y    = 10'd30;
        line_start = 1;
        tick();
        line_start = 0;
        wr_en    = 1;
        wr_idx   = 3'd0;
        wr_valid = 1;
        wr_type  = 3'd5;
        wr_x     = 10'd222;
        wr_y     = 10'd30;
        tick();
        wr_en = 0;
        chk("old entry used", 64'(eng_start), 64'd0);
        for (int j = 1; j < NS; j++) begin
            line_start = (j == 3);
            tick();
            chk($sformatf("ovr entry%0d", j), 64'(eng_start),
                64'((j == 7) ? 4'b0001 : 4'b0000));
        end
        line_start = 0;
        acc = '0;
        for (int k = 0; k < NS + 2; k++) begin
            tick();
            acc = acc | eng_start;
        end
        chk("no restarted scan", 64'(acc), 64'd0);
        chk("overrun set", 64'(overrun), 64'd1);
        m_valid[0] = 1;
        m_type[0]  = 3'd5;
        m_xt[0]    = 10'd222;
        m_yt[0]    = 10'd30;
        m_spr[0]   = 3'd6;
        m_x[0]     = 10'd700;
        m_own[0]   = 7;
        pulse_clr();
        chk("overrun clr", 64'(overrun), 64'd0);
        run_line(10'd30, bz);

        // reset in the middle of a scan
        do_reset();
        wr(0, 1, 3'd5, 10'd9, 10'd60);
        pixel_y    = 10'd60;
        line_start = 1;
        tick();
        line_start = 0;
        eng_draw   = 4'b0001;
        tick();
        chk("pre-rst start", 64'(eng_start), 64'd1);
        chk("pre-rst pix_on", 64'(pix_on), 64'd1);
        rst = 1;
        #1;
        chk("rst start drop", 64'(eng_start), 64'd0);
        chk("rst pix_on drop", 64'(pix_on), 64'd0);
        tick();
        eng_draw = '0;
        do_reset();
        run_line(10'd60, bz);
        chk("post-rst x0", 64'(eng_x), 64'd0);

        // randomized lines against the model
        do_reset();
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < 3; k++)
                wr($urandom_range(0, NS - 1), ($urandom % 4) != 0,
                   3'($urandom), 10'($urandom), 10'(40 + $urandom % 3));
            for (int j = 0; j < NS; j++) bs[j] = 4'($urandom & $urandom);
            run_line(10'(40 + $urandom % 3), bs);
            for (int k = 0; k < 3; k++) draw_chk(4'($urandom));
            if ($urandom % 4 == 0) begin
                pulse_clr();
                chk("rand clr", 64'(ovf), 64'd0);
            end
        end
        chk("rand overrun", 64'(overrun), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
